axi_write_slave: RTL and testbench

//  AXI3 write-path slave placed behind the bus-functional model, as the DUV end of the write channels.

---
 rtl/axiprotocol.sv | 32 +++
 rtl/axi_strb_mem.sv | 33 +++
 rtl/axi_write_slave.sv | 195 +++++++++++++++++++
 tb/tb_axi_write_slave.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axiprotocol.sv
// Shared AXI3 write-path types and the per-beat address sequencer.
package axiprotocol;

  localparam int unsigned AddrW = 32;
  localparam int unsigned LenW  = 4;
  localparam int unsigned SizeW = 3;

  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11} burst_t;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  // Address of the beat following the one at addr.
  function automatic logic [AddrW-1:0] next_addr(input logic [AddrW-1:0] addr,
                                                 input logic [SizeW-1:0] size,
                                                 input logic [LenW-1:0]  len,
                                                 input burst_t           burst);
    logic [AddrW-1:0] bytes;
    logic [AddrW-1:0] mask;
    logic [AddrW-1:0] nxt;
    bytes = AddrW'(1) << size;
    // Wrap window is bytes*(len+1); only meaningful for power-of-two windows.
    mask  = (bytes * (AddrW'(len) + AddrW'(1))) - AddrW'(1);
    case (burst)
      FIXED:   nxt = addr;
      INCR:    nxt = (addr + bytes) & ~(bytes - AddrW'(1));
      WRAP:    nxt = (addr & ~mask) | ((addr + bytes) & mask);
      default: nxt = addr;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/axi_strb_mem.sv
// Word memory with byte-strobed synchronous write and asynchronous read.
module axi_strb_mem #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 256
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [Width/8-1:0]       wstrb_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Strobed write; contents deliberately have no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < Width / 8; i++) begin
        if (wstrb_i[i]) begin
          mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Debug read port.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/axi_write_slave.sv
// AXI3 write-channel slave: one burst at a time into a strobed word memory, one B per burst.
module axi_write_slave
  import axiprotocol::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SIZE      = 3,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [WIDTH/8-1:0]           AWID,
  input  logic [WIDTH-1:0]             AWADDR,
  input  logic [WIDTH/8-1:0]           AWLEN,
  input  logic [SIZE-1:0]              AWSIZE,
  input  logic [SIZE-2:0]              AWBURST,
  input  logic                         WVALID,
  output logic                         WREADY,
  input  logic [WIDTH/8-1:0]           WID,
  input  logic [WIDTH-1:0]             WDATA,
  input  logic [WIDTH/8-1:0]           WSTRB,
  input  logic                         WLAST,
  output logic                         BVALID,
  input  logic                         BREADY,
  output logic [WIDTH/8-1:0]           BID,
  output logic [SIZE-2:0]              BRESP,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [WIDTH-1:0]             dbg_data
);

  localparam int unsigned StrbW   = WIDTH / 8;
  localparam int unsigned AddrLsb = $clog2(StrbW);
  localparam int unsigned IdxW    = $clog2(MEM_DEPTH);
  localparam logic [WIDTH-1:0] MemBytes = WIDTH'(MEM_DEPTH * StrbW);
  localparam logic [SIZE-1:0]  MaxSize  = SIZE'(AddrLsb);

  wstate_t            state_q, state_d;
  logic               awready_q, awready_d;
  logic               wready_q, wready_d;
  logic               bvalid_q, bvalid_d;
  logic [StrbW-1:0]   bid_q, bid_d;
  resp_t              bresp_q, bresp_d;
  logic [StrbW-1:0]   id_q, id_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [StrbW-1:0]   len_q, len_d;
  logic [SIZE-1:0]    size_q, size_d;
  burst_t             burst_q, burst_d;
  logic [StrbW-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  // Burst was rejected at AW time: beats are accepted but never written.
  logic               skip_q, skip_d;

  logic               aw_hs, w_hs, last_beat, oob, beat_err, bad_burst, wrap_len_ok;
  logic               mem_we;
  logic [IdxW-1:0]    mem_waddr;

  // Handshake and per-beat error decode.
  always_comb begin
    aw_hs       = AWVALID && awready_q;
    w_hs        = WVALID && wready_q;
    last_beat   = (cnt_q == len_q);
    oob         = (addr_q >= MemBytes);
    beat_err    = (WLAST != last_beat) || (WID != id_q) || oob;
    wrap_len_ok = (AWLEN == StrbW'(1)) || (AWLEN == StrbW'(3)) ||
                  (AWLEN == StrbW'(7)) || (AWLEN == StrbW'(15));
    bad_burst   = (burst_t'(AWBURST) == RSVD) || (AWSIZE > MaxSize) ||
                  ((burst_t'(AWBURST) == WRAP) && !wrap_len_ok);
    mem_we      = w_hs && !skip_q && !oob;
    mem_waddr   = addr_q[AddrLsb +: IdxW];
  end

  // Next-state for the IDLE -> DATA -> RESP sequence and its registered outputs.
  always_comb begin
    state_d   = state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    skip_d    = skip_q;
    case (state_q)
      W_IDLE: begin
        if (aw_hs) begin
          id_d      = AWID;
          addr_d    = AWADDR;
          len_d     = AWLEN;
          size_d    = AWSIZE;
          burst_d   = burst_t'(AWBURST);
          cnt_d     = '0;
          err_d     = bad_burst;
          skip_d    = bad_burst;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          state_d   = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          cnt_d  = cnt_q + StrbW'(1);
          addr_d = next_addr(addr_q, size_q, len_q, burst_q);
          if (beat_err) begin
            err_d = 1'b1;
          end
          // Termination is by beat count only; WLAST just feeds the error flag.
          if (last_beat) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = (err_q || beat_err) ? SLVERR : OKAY;
            state_d  = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = W_IDLE;
        end
      end
      default: begin
        state_d   = W_IDLE;
        awready_d = 1'b1;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= OKAY;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= FIXED;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      skip_q    <= skip_d;
    end
  end

  // Output ports.
  always_comb begin
    AWREADY = awready_q;
    WREADY  = wready_q;
    BVALID  = bvalid_q;
    BID     = bid_q;
    BRESP   = bresp_q;
  end

  axi_strb_mem #(
    .Width (WIDTH),
    .Depth (MEM_DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (WDATA),
    .wstrb_i (WSTRB),
    .raddr_i (dbg_addr),
    .rdata_o (dbg_data)
  );

endmodule

// File: tb/tb_axi_write_slave.sv
// Bench for axi_write_slave: directed bursts, a burst-level memory/response model, and a
// per-cycle compare process sweeping the debug port.
module tb_axi_write_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        AWVALID = 1'b0, AWREADY;
  logic [3:0]  AWID = '0;
  logic [31:0] AWADDR = '0;
  logic [3:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = '0;
  logic [1:0]  AWBURST = '0;
  logic        WVALID = 1'b0, WREADY;
  logic [3:0]  WID = '0;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        BVALID, BREADY = 1'b0;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_data;

  always #5 clk = ~clk;

  axi_write_slave #(
    .WIDTH     (32),
    .SIZE      (3),
    .MEM_DEPTH (256)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .AWID     (AWID),
    .AWADDR   (AWADDR),
    .AWLEN    (AWLEN),
    .AWSIZE   (AWSIZE),
    .AWBURST  (AWBURST),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .WID      (WID),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WLAST    (WLAST),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .BID      (BID),
    .BRESP    (BRESP),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model memory plus per-byte "known" flags (DUT memory starts undefined).
  logic [31:0] m_mem [256];
  logic [3:0]  m_kn  [256];

  // Beat stimulus shared by the burst driver.
  logic [31:0] bd [16];
  logic [3:0]  bs [16];
  logic [3:0]  bw [16];
  logic        bl [16];

  logic       peek_busy = 1'b0;
  logic [7:0] peek_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Beat address from the burst rules in closed form.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int size,
                                            input int len, input int burst, input int i);
    logic [31:0] bytes, span, base;
    bytes = 32'(1) << size;
    span  = bytes * 32'(len + 1);
    base  = start & ~(span - 32'(1));
    case (burst)
      1:       return (i == 0) ? start : (start & ~(bytes - 32'(1))) + bytes * 32'(i);
      2:       return base + ((start - base + bytes * 32'(i)) % span);
      default: return start;
    endcase
  endfunction

  task automatic prep(input logic [3:0] id, input int len);
    for (int i = 0; i < 16; i++) begin
      bd[i] = 32'h0;
      bs[i] = 4'hF;
      bw[i] = id;
      bl[i] = (i == len);
    end
  endtask

  // Drives one burst and checks its response; abort_at >= 0 pulls reset before that beat.
  task automatic send_burst(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input int len, input int size, input int burst, input int hold,
                            input int abort_at, input logic [1:0] exp_resp);
    logic        bad, err;
    logic [31:0] a;
    logic [1:0]  resp;
    int          t;
    bad = (burst == 3) || (size > 2) ||
          ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
    err = bad;
    AWVALID = 1'b1;
    AWID    = id;
    AWADDR  = addr;
    AWLEN   = 4'(len);
    AWSIZE  = 3'(size);
    AWBURST = 2'(burst);
    t = 0;
    @(negedge clk);
    while (!AWREADY && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "/awready"}, 32'(AWREADY), 32'd1);
    if (!AWREADY) begin
      AWVALID = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (i == abort_at) begin
        reset  = 1'b0;
        WVALID = 1'b0;
        @(negedge clk);
        check({tag, "/rst_awready"}, 32'(AWREADY), 32'd1);
        check({tag, "/rst_wready"}, 32'(WREADY), 32'd0);
        check({tag, "/rst_bvalid"}, 32'(BVALID), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        return;
      end
      WVALID = 1'b1;
      WID    = bw[i];
      WDATA  = bd[i];
      WSTRB  = bs[i];
      WLAST  = bl[i];
      @(negedge clk);
      check({tag, "/wready"}, 32'(WREADY), 32'd1);
      if (!WREADY) begin
        WVALID = 1'b0;
        return;
      end
      @(posedge clk);
      a = beat_addr(addr, size, len, burst, i);
      if (bw[i] != id) err = 1'b1;
      if (bl[i] != (i == len)) err = 1'b1;
      if (a >= 32'd1024) begin
        err = 1'b1;
      end else if (!bad) begin
        for (int j = 0; j < 4; j++) begin
          if (bs[i][j]) begin
            m_mem[a[9:2]][8*j +: 8] = bd[i][8*j +: 8];
            m_kn[a[9:2]][j] = 1'b1;
          end
        end
      end
      #1;
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    resp   = err ? 2'b10 : 2'b00;
    check({tag, "/model_resp"}, 32'(resp), 32'(exp_resp));
    @(negedge clk);
    check({tag, "/wready_drop"}, 32'(WREADY), 32'd0);
    check({tag, "/bvalid"}, 32'(BVALID), 32'd1);
    check({tag, "/bid"}, 32'(BID), 32'(id));
    check({tag, "/bresp"}, 32'(BRESP), 32'(resp));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check({tag, "/hold_bvalid"}, 32'(BVALID), 32'd1);
      check({tag, "/hold_bid"}, 32'(BID), 32'(id));
      check({tag, "/hold_bresp"}, 32'(BRESP), 32'(resp));
      check({tag, "/hold_awready"}, 32'(AWREADY), 32'd0);
    end
    @(posedge clk);
    #1;
    BREADY = 1'b1;
    @(negedge clk);
    check({tag, "/awready_b"}, 32'(AWREADY), 32'd0);
    @(posedge clk);
    #1;
    BREADY = 1'b0;
    @(negedge clk);
    check({tag, "/bvalid_done"}, 32'(BVALID), 32'd0);
    check({tag, "/awready_done"}, 32'(AWREADY), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Reads one word through the debug port against a literal.
  task automatic peek(input int w, input logic [31:0] exp, input string name);
    peek_addr = 8'(w);
    peek_busy = 1'b1;
    @(posedge clk);
    #2;
    @(negedge clk);
    check(name, dbg_data, exp);
    peek_busy = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Debug address sweep, overridden during peeks.
  initial begin
    dbg_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      dbg_addr = peek_busy ? peek_addr : dbg_addr + 8'd1;
    end
  end

  // Every-cycle compare against the model and the response-channel rules.
  initial begin : cmp
    logic        pbv, pbr;
    logic [3:0]  pbid;
    logic [1:0]  pbresp;
    logic [31:0] mask;
    pbv = 1'b0;
    pbr = 1'b0;
    pbid = '0;
    pbresp = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("cmp/rst_awready", 32'(AWREADY), 32'd1);
        check("cmp/rst_wready", 32'(WREADY), 32'd0);
        check("cmp/rst_bvalid", 32'(BVALID), 32'd0);
        pbv = 1'b0;
      end else begin
        mask = {{8{m_kn[dbg_addr][3]}}, {8{m_kn[dbg_addr][2]}},
                {8{m_kn[dbg_addr][1]}}, {8{m_kn[dbg_addr][0]}}};
        if (mask != 32'h0) begin
          check("cmp/dbg_data", dbg_data & mask, m_mem[dbg_addr] & mask);
        end
        if (pbv && !pbr) begin
          check("cmp/b_stable_valid", 32'(BVALID), 32'd1);
          check("cmp/b_stable_id", 32'(BID), 32'(pbid));
          check("cmp/b_stable_resp", 32'(BRESP), 32'(pbresp));
        end
        if (AWREADY && WREADY) begin
          check("cmp/aw_w_exclusive", 32'(WREADY), 32'd0);
        end
        pbv    = BVALID;
        pbr    = BREADY;
        pbid   = BID;
        pbresp = BRESP;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      m_mem[i] = '0;
      m_kn[i]  = '0;
    end
    prep(4'd0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset/bid", 32'(BID), 32'd0);
    check("reset/bresp", 32'(BRESP), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // INCR burst into words 4..7.
    prep(4'd5, 3);
    for (int i = 0; i < 4; i++) bd[i] = 32'hA0 + 32'(i);
    send_burst("incr", 4'd5, 32'h10, 3, 2, 1, 0, -1, 2'b00);
    for (int i = 0; i < 4; i++) peek(4 + i, 32'hA0 + 32'(i), "incr/mem");

    // WRAP from 0x38: words 14,15,12,13.
    prep(4'd5, 3);
    for (int i = 0; i < 4; i++) bd[i] = 32'hB0 + 32'(i);
    send_burst("wrap", 4'd5, 32'h38, 3, 2, 2, 0, -1, 2'b00);
    peek(14, 32'hB0, "wrap/mem14");
    peek(15, 32'hB1, "wrap/mem15");
    peek(12, 32'hB2, "wrap/mem12");
    peek(13, 32'hB3, "wrap/mem13");

    // Byte strobes.
    prep(4'd3, 0);
    bd[0] = 32'h11223344;
    send_burst("strb_init", 4'd3, 32'h0, 0, 2, 1, 0, -1, 2'b00);
    bd[0] = 32'hAABBCCDD;
    bs[0] = 4'b0101;
    send_burst("strb", 4'd3, 32'h0, 0, 2, 1, 0, -1, 2'b00);
    peek(0, 32'h11BB33DD, "strb/mem0");

    // Early WLAST: all four beats accepted and written, SLVERR held for 3 cycles.
    prep(4'd1, 3);
    for (int i = 0; i < 4; i++) bd[i] = 32'hC0 + 32'(i);
    bl[1] = 1'b1;
    send_burst("early_wlast", 4'd1, 32'h40, 3, 2, 1, 3, -1, 2'b10);
    peek(19, 32'hC3, "early_wlast/mem19");

    // WID mismatch: written anyway, SLVERR.
    prep(4'd1, 0);
    bw[0] = 4'd2;
    bd[0] = 32'hD0;
    send_burst("wid", 4'd1, 32'h50, 0, 2, 1, 0, -1, 2'b10);
    peek(20, 32'hD0, "wid/mem20");

    // BREADY held low for 10 cycles.
    prep(4'd7, 1);
    bd[0] = 32'h600D0001;
    bd[1] = 32'h600D0002;
    send_burst("bhold", 4'd7, 32'h60, 1, 2, 1, 10, -1, 2'b00);

    // Reset after beat 2, then a fresh burst.
    prep(4'd2, 3);
    for (int i = 0; i < 4; i++) bd[i] = 32'hE0 + 32'(i);
    send_burst("abort", 4'd2, 32'h70, 3, 2, 1, 0, 3, 2'b00);
    peek(30, 32'hE2, "abort/mem30");
    prep(4'd4, 1);
    bd[0] = 32'h12345678;
    bd[1] = 32'h9ABCDEF0;
    send_burst("after_abort", 4'd4, 32'h80, 1, 2, 1, 0, -1, 2'b00);
    peek(33, 32'h9ABCDEF0, "after_abort/mem33");

    // Rejected bursts leave word 40 untouched.
    prep(4'd6, 0);
    bd[0] = 32'hDEADBEEF;
    send_burst("rsvd_init", 4'd6, 32'hA0, 0, 2, 1, 0, -1, 2'b00);
    bd[0] = 32'h0BADF00D;
    send_burst("rsvd", 4'd6, 32'hA0, 0, 2, 3, 0, -1, 2'b10);
    send_burst("oversize", 4'd6, 32'hA0, 0, 3, 1, 0, -1, 2'b10);
    prep(4'd6, 2);
    send_burst("wrap_len2", 4'd6, 32'hA0, 2, 2, 2, 0, -1, 2'b10);
    peek(40, 32'hDEADBEEF, "rejected/mem40");

    // Second beat crosses the top of memory.
    prep(4'd9, 1);
    bd[0] = 32'hF0;
    bd[1] = 32'hF1;
    send_burst("oob", 4'd9, 32'h3FC, 1, 2, 1, 0, -1, 2'b10);
    peek(255, 32'hF0, "oob/mem255");

    // FIXED: every beat hits word 44.
    prep(4'd9, 2);
    for (int i = 0; i < 3; i++) bd[i] = 32'(i + 1);
    send_burst("fixed", 4'd9, 32'hB0, 2, 2, 0, 0, -1, 2'b00);
    peek(44, 32'h3, "fixed/mem44");

    // Byte-sized INCR into word 48.
    prep(4'd9, 0);
    send_burst("narrow_init", 4'd9, 32'hC0, 0, 2, 1, 0, -1, 2'b00);
    prep(4'd9, 2);
    for (int i = 0; i < 3; i++) begin
      bd[i] = 32'h44332211;
      bs[i] = 4'(1 << (i + 1));
    end
    send_burst("narrow", 4'd9, 32'hC1, 2, 0, 1, 0, -1, 2'b00);
    peek(48, 32'h44332200, "narrow/mem48");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
